// File: rtl/inst_encode_loader_if.sv
// Bundle for inst_encode_loader: field-set handshake, restart pulse, the
// instruction-memory write port and the status outputs.
interface inst_encode_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
) ();
    // Field-set handshake
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            imm_sel;
    logic [31:0]           imm;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    // Load control
    logic                  start;
    // Instruction-memory write port
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    // Status
    logic [ADDR_WIDTH:0]   word_count;
    logic                  busy;
    logic                  imm_err;

    // Producer of field sets and owner of the memory
    modport master (
        output in_valid, imm_sel, imm, opcode, rd, rs1, rs2, funct3, funct7, start, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, imm_err
    );

    // The encoder/loader itself
    modport slave (
        input  in_valid, imm_sel, imm, opcode, rd, rs1, rs2, funct3, funct7, start, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, imm_err
    );
endinterface

// File: rtl/inst_encode_loader.sv
// Sequential RV32 instruction encoder and program loader.
// Scatters a full immediate back into RV32 bit positions (same format coding as
// the ID stage), queues the encoded words in a FIFO and writes them to
// instruction memory at consecutive word addresses through an ack-based port.
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that do not
// fit the selected format (sticky imm_err); otherwise imm_err is tied low.
module inst_encode_loader #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                reset,
    inst_encode_loader_if.slave bus
);
    localparam int unsigned           PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e                state_q, state_d;
    logic [31:0]           fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  we_q, we_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  start_ok;
    logic [31:0]           enc_word;

    assign fifo_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.in_valid & ~fifo_full;

    // Encode the field set into an RV32 word; 110 is reserved and encodes as R
    always_comb begin
        enc_word = '0;
        case (bus.imm_sel)
            3'b000: enc_word = {bus.imm[31:12], bus.rd, bus.opcode};
            3'b001: enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                                bus.rd, bus.opcode};
            3'b010: enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'b011: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                                bus.imm[4:1], bus.imm[11], bus.opcode};
            3'b100: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0],
                                bus.opcode};
            3'b101: enc_word = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd,
                                bus.opcode};
            default: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        endcase
    end

    // Writer FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Writer FSM next state, FIFO pop, address/count advance and restart
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        addr_d   = addr_q;
        wc_d     = wc_q;
        wdata_d  = wdata_q;
        // Restart only when nothing is in flight so no queued word is misplaced
        start_ok = bus.start & (state_q == StIdle) & fifo_empty;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    wdata_d = fifo_mem[rptr_q];
                    state_d = StWrite;
                end else if (start_ok) begin
                    addr_d = BASE;
                    wc_d   = '0;
                end
            end
            StWrite: begin
                if (bus.mem_ack) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    wc_d   = wc_q + (ADDR_WIDTH+1)'(1);
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        wdata_d = fifo_mem[rptr_q];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO pointer/occupancy next state and registered status outputs
    always_comb begin
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
        we_d   = (state_d == StWrite);
        busy_d = (count_d != '0) | (state_d == StWrite);
    end

    // FIFO storage; reset drops queued words through the pointers alone
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= enc_word;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            addr_q  <= BASE;
            wc_q    <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic imm_bad;
    logic imm_err_q, imm_err_d;

    // Immediate does not fit the selected format (signed fits: upper bits all equal)
    always_comb begin
        imm_bad = 1'b0;
        case (bus.imm_sel)
            3'b000: imm_bad = (bus.imm[11:0] != '0);
            3'b001: imm_bad = bus.imm[0] | ~((&bus.imm[31:20]) | ~(|bus.imm[31:20]));
            3'b010,
            3'b100: imm_bad = ~((&bus.imm[31:11]) | ~(|bus.imm[31:11]));
            3'b011: imm_bad = bus.imm[0] | ~((&bus.imm[31:12]) | ~(|bus.imm[31:12]));
            3'b101: imm_bad = (bus.imm[31:5] != '0);
            default: imm_bad = 1'b0;
        endcase
        // Restart clears the flag; a word accepted alongside it can set it again
        imm_err_d = (start_ok ? 1'b0 : imm_err_q) | (push & imm_bad);
    end

    // Sticky range-violation flag
    always_ff @(posedge clk) begin
        if (reset) begin
            imm_err_q <= 1'b0;
        end else begin
            imm_err_q <= imm_err_d;
        end
    end

    assign bus.imm_err = imm_err_q;
`else
    assign bus.imm_err = 1'b0;
`endif

    assign bus.in_ready   = ~fifo_full;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.word_count = wc_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader: encodings per format, zero-wait and
// back-pressured writes, address wrap, START gating, reset mid-write and the
// optional immediate range flag.
module tb_inst_encode_loader;
    localparam int unsigned AW   = 2;
    localparam int unsigned BASE = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0]   exp_q[$];
    logic [31:0]   rec_data[$];
    logic [AW-1:0] rec_addr[$];
    logic [AW-1:0] exp_addr;
    logic [AW:0]   exp_wc;
    logic [31:0]   exp_err;

    inst_encode_loader_if #(.ADDR_WIDTH(AW)) bus ();

    inst_encode_loader #(
        .DEPTH     (4),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory side: log every accepted write
    always @(posedge clk) begin
        if (!reset && bus.mem_we && bus.mem_ack) begin
            rec_data.push_back(bus.mem_wdata);
            rec_addr.push_back(bus.mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] sel, input logic [31:0] imm, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] word);
        int n = 0;
        bus.imm_sel  = sel;
        bus.imm      = imm;
        bus.opcode   = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!bus.in_ready) check("push_ready", 32'(bus.in_ready), 32'd1);
        tick(1);
        bus.in_valid = 1'b0;
        exp_q.push_back(word);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (bus.busy && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_count"}, 32'(rec_data.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rec_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), rec_data[i], exp_q[i]);
            check($sformatf("%s_addr%0d", tag, i), 32'(rec_addr[i]), 32'(exp_addr));
            exp_addr++;
            exp_wc++;
        end
        check({tag, "_wc"}, 32'(bus.word_count), 32'(exp_wc));
        check({tag, "_maddr"}, 32'(bus.mem_addr), 32'(exp_addr));
        exp_q.delete();
        rec_data.delete();
        rec_addr.delete();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.imm_sel  = '0;
        bus.imm      = '0;
        bus.opcode   = '0;
        bus.rd       = '0;
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.funct3   = '0;
        bus.funct7   = '0;
        bus.start    = 1'b0;
        bus.mem_ack  = 1'b0;
        reset        = 1'b1;
        exp_addr     = AW'(BASE);
        exp_wc       = '0;
        tick(3);

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'(BASE));
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_wc", 32'(bus.word_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_imm_err", 32'(bus.imm_err), 32'd0);
        reset = 1'b0;
        tick(1);

        // LUI x1 / ADDI x1,x0,-1 with zero-wait memory
        bus.mem_ack = 1'b1;
        push(3'b000, 32'h1234_5000, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_50B7);
        push(3'b010, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0093);
        drain("lui_addi");

        // START when idle restarts at the base address
        pulse_start();
        exp_addr = AW'(BASE);
        exp_wc   = '0;
        check("start_addr", 32'(bus.mem_addr), 32'(BASE));
        check("start_wc", 32'(bus.word_count), 32'd0);

        // One of each remaining format; seven words wrap the 2-bit address
        push(3'b011, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFE00_0EE3);
        push(3'b100, 32'hFFFF_FFFF, 7'h23, 5'd0, 5'd0, 5'd2, 3'd2, 7'h00, 32'hFE20_2FA3);
        push(3'b101, 32'h0000_0001, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'h0010_9093);
        push(3'b001, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_00EF);
        push(3'b110, 32'hFFFF_FFFF, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0020_81B3);
        push(3'b111, 32'hFFFF_FFFF, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h4020_81B3);
        check("err_clean", 32'(bus.imm_err), 32'd0);
        // I-type immediate 2048 is out of range; still encoded with field 0x800
        push(3'b010, 32'h0000_0800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_0093);
`ifdef IMM_RANGE_CHECK_EN
        exp_err = 32'd1;
`else
        exp_err = 32'd0;
`endif
        check("err_set", 32'(bus.imm_err), exp_err);
        drain("mix");
        check("err_sticky", 32'(bus.imm_err), exp_err);
        pulse_start();
        exp_addr = AW'(BASE);
        exp_wc   = '0;
        check("start2_addr", 32'(bus.mem_addr), 32'(BASE));
        check("start2_wc", 32'(bus.word_count), 32'd0);
        check("start2_err", 32'(bus.imm_err), 32'd0);

        // Back-pressure: DEPTH+1 words fill the loader, outputs hold, START ignored
        bus.mem_ack = 1'b0;
        push(3'b010, 32'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0093);
        check("lat_we0", 32'(bus.mem_we), 32'd0);
        check("lat_busy0", 32'(bus.busy), 32'd1);
        push(3'b010, 32'd2, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0020_0093);
        check("lat_we1", 32'(bus.mem_we), 32'd1);
        check("lat_wdata1", bus.mem_wdata, 32'h0010_0093);
        push(3'b010, 32'd3, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0030_0093);
        push(3'b010, 32'd4, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0040_0093);
        push(3'b010, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0050_0093);
        check("bp_full", 32'(bus.in_ready), 32'd0);
        pulse_start();
        tick(2);
        check("bp_we", 32'(bus.mem_we), 32'd1);
        check("bp_addr", 32'(bus.mem_addr), 32'(BASE));
        check("bp_wdata", bus.mem_wdata, 32'h0010_0093);
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        bus.mem_ack = 1'b1;
        drain("bp");

        // Reset mid-write with three words queued drops everything
        bus.mem_ack = 1'b0;
        push(3'b010, 32'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0060_0093);
        push(3'b010, 32'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0070_0093);
        push(3'b010, 32'd8, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0080_0093);
        push(3'b010, 32'd9, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0090_0093);
        check("pre_rst_we", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_we", 32'(bus.mem_we), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_addr", 32'(bus.mem_addr), 32'(BASE));
        check("mid_rst_wc", 32'(bus.word_count), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        rec_data.delete();
        rec_addr.delete();
        bus.mem_ack = 1'b1;
        tick(10);
        check("rst_dropped", 32'(rec_data.size()), 32'd0);
        check("rst_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
